// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM line, used by both the sink-side demux and
// the source-side mux wrapper.
//   NUM_CH       : number of time slots / channels (fixed by the 2-bit select)
//   SEL_W        : width of the slot select {S1,S0}
//   sync_state_t : frame-lock state of the receiver
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } sync_state_t;

endpackage : tdm_pkg

// File: rtl/tdm_demux_4ch_if.sv
// Per-channel output bus of the TDM demux: one valid/ready word channel per
// slot plus the sticky overflow flags and their clear strobes.
//   ch_data  : channel c word at [c*WIDTH +: WIDTH]
//   ch_valid : per-channel word available
//   ch_ready : per-channel consumer accept
//   ovf      : sticky per-channel overflow
//   ovf_clr  : clears the matching ovf bit
// master = demux side, slave = consumer side.
interface tdm_demux_4ch_if #(
    parameter int WIDTH = 8
) ();
    import tdm_pkg::*;

    logic [NUM_CH*WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_ready;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       ovf_clr;

    modport master (
        output ch_data,
        output ch_valid,
        output ovf,
        input  ch_ready,
        input  ovf_clr
    );

    modport slave (
        input  ch_data,
        input  ch_valid,
        input  ovf,
        output ch_ready,
        output ovf_clr
    );

endinterface : tdm_demux_4ch_if

// File: rtl/tdm_demux_4ch_chan_rx.sv
// One receive channel of the TDM demux: assembles MSB-first bits into a word,
// buffers the completed word behind a valid/ready handshake and flags words
// that arrive while the buffer is still occupied.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : resync strobe, discards the partial word in progress
//   sample   : this channel's slot is active and the line carries a bit
//   bit_in   : serial line value
//   ready    : consumer accept
//   ovf_clr  : clear request for the sticky overflow flag
//   data     : buffered word
//   valid    : buffered word available
//   ovf      : sticky overflow flag
module tdm_chan_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sample,
    input  logic             bit_in,
    input  logic             ready,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] word;
    logic             last;
    logic             accept;
    logic             load;

    // The completed word includes the bit arriving this cycle.
    assign word   = {shift_reg[WIDTH-2:0], bit_in};
    assign last   = sample && (cnt_reg == CNT_W'(WIDTH - 1));
    assign accept = valid_reg && ready;
    // The buffer can take a new word if it is empty or being drained now.
    assign load   = last && (!valid_reg || ready);

    // A resync in the same cycle as a last bit still lets that word load
    // (load uses the combinational word), but the assembly state clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (sample) begin
            shift_reg <= word;
            cnt_reg   <= last ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                data_reg <= word;
            end
            if (load) begin
                valid_reg <= 1'b1;
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
        end
    end

    // Setting wins over clearing so a drop is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (last && !load) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
    assign ovf   = ovf_reg;

endmodule : tdm_chan_rx

// File: rtl/tdm_demux_4ch.sv
// Sink end of the shared TDM line. Drives the slot select back to the source
// mux, locks onto frame_start, samples the line once per slot and hands each
// slot's bits to its own receive channel.
//   clk, rst    : clock and asynchronous active-high reset
//   line_d      : shared serial line value
//   line_vld    : line actively driven this cycle (low = idle / high-Z)
//   frame_start : 1-cycle sync pulse, the following cycle is slot 0
//   sel         : registered current slot {S1,S0}
//   locked      : receiver is in SYNC
//   sync_err    : 1-cycle pulse on a frame_start outside the slot-3 boundary
//   chan        : per-channel word outputs (master side)
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line_d,
    input  logic                    line_vld,
    input  logic                    frame_start,
    output logic [SEL_W-1:0]        sel,
    output logic                    locked,
    output logic                    sync_err,
    tdm_demux_4ch_if.master         chan
);

    sync_state_t       state_reg;
    sync_state_t       state_next;
    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  sel_next;
    logic              sync_err_reg;
    logic              sync_err_next;
    logic              resync;

    logic [NUM_CH-1:0]       sample_vec;
    logic [NUM_CH-1:0]       valid_vec;
    logic [NUM_CH-1:0]       ovf_vec;
    logic [WIDTH-1:0]        data_arr [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] data_flat;

    // Slot counter runs regardless of lock so the source keeps cycling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= UNSYNC;
            sel_reg      <= '0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            sync_err_reg <= sync_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = frame_start ? '0 : sel_reg + SEL_W'(1);
        sync_err_next = 1'b0;
        resync        = 1'b0;
        case (state_reg)
            UNSYNC: begin
                if (frame_start) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                // frame_start right after the last slot is the normal
                // boundary; anywhere else the frame alignment was lost.
                if (frame_start && (sel_reg != SEL_W'(NUM_CH - 1))) begin
                    resync        = 1'b1;
                    sync_err_next = 1'b1;
                end
            end
            default: begin
                state_next = UNSYNC;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign sample_vec[gi] = (state_reg == SYNC) && line_vld
                                    && (sel_reg == SEL_W'(gi));

            tdm_chan_rx #(
                .WIDTH (WIDTH)
            ) u_chan_rx (
                .clk     (clk),
                .rst     (rst),
                .clr     (resync),
                .sample  (sample_vec[gi]),
                .bit_in  (line_d),
                .ready   (chan.ch_ready[gi]),
                .ovf_clr (chan.ovf_clr[gi]),
                .data    (data_arr[gi]),
                .valid   (valid_vec[gi]),
                .ovf     (ovf_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        data_flat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            data_flat[i*WIDTH +: WIDTH] = data_arr[i];
        end
    end

    assign chan.ch_data  = data_flat;
    assign chan.ch_valid = valid_vec;
    assign chan.ovf      = ovf_vec;

    assign sel      = sel_reg;
    assign locked   = (state_reg == SYNC);
    assign sync_err = sync_err_reg;

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
module tb_tdm_demux_4ch;
    import tdm_pkg::*;

    localparam int W  = 8;
    localparam int VW = 12 + 4 * W;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_d;
    logic       line_vld;
    logic       frame_start;
    logic [1:0] sel;
    logic       locked;
    logic       sync_err;

    tdm_demux_4ch_if #(.WIDTH(W)) bus ();

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .line_d      (line_d),
        .line_vld    (line_vld),
        .frame_start (frame_start),
        .sel         (sel),
        .locked      (locked),
        .sync_err    (sync_err),
        .chan        (bus.master)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: slot number, lock flag, per-channel bit tally
    // and running value, and the per-channel output buffer.
    int         m_sel;
    bit         m_locked;
    bit         m_serr;
    int         m_n   [4];
    int         m_acc [4];
    logic [W-1:0] m_data [4];
    bit         m_valid [4];
    bit         m_ovf   [4];

    // Transmit-side stimulus state.
    logic [W-1:0] tx_word [4];
    bit           vld_en  [4];

    task automatic model_reset();
        m_sel = 0; m_locked = 0; m_serr = 0;
        for (int c = 0; c < 4; c++) begin
            m_n[c] = 0; m_acc[c] = 0; m_data[c] = '0; m_valid[c] = 0; m_ovf[c] = 0;
        end
    endtask

    // Advances the reference by one clock using the inputs currently applied.
    task automatic model_step();
        int c;
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && bus.ch_ready[i]) m_valid[i] = 0;
            if (bus.ovf_clr[i]) m_ovf[i] = 0;
        end
        if (m_locked && line_vld) begin
            c = m_sel;
            m_acc[c] = (m_acc[c] * 2 + int'(line_d)) % (1 << W);
            m_n[c]   = m_n[c] + 1;
            if (m_n[c] == W) begin
                m_n[c] = 0;
                if (!m_valid[c]) begin
                    m_data[c]  = W'(m_acc[c]);
                    m_valid[c] = 1;
                end else begin
                    m_ovf[c] = 1;
                end
            end
        end
        m_serr = 0;
        if (frame_start) begin
            if (m_locked && m_sel != 3) begin
                m_serr = 1;
                for (int i = 0; i < 4; i++) begin
                    m_n[i] = 0; m_acc[i] = 0;
                end
            end
            m_locked = 1;
            m_sel    = 0;
        end else begin
            m_sel = (m_sel + 1) % 4;
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [3:0]     v;
        logic [3:0]     o;
        logic [4*W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            v[i] = m_valid[i];
            o[i] = m_ovf[i];
            d[i*W +: W] = m_data[i];
        end
        return {2'(m_sel), m_locked, m_serr, v, o, d};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {sel, locked, sync_err, bus.ch_valid, bus.ovf, bus.ch_data};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Puts the next bit of the current slot's channel word on the line.
    task automatic drive(input bit fs);
        int c;
        c = m_sel;
        line_vld    = vld_en[c];
        line_d      = tx_word[c][W-1-m_n[c]];
        frame_start = fs;
        step();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; line_d = 0; line_vld = 0; frame_start = 0;
        bus.ch_ready = '0; bus.ovf_clr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== '0)
            begin errors++; $display("FAIL reset_state: got %h required 0", dut_vec()); end
        rst = 1'b0;
        line_vld = 1'b1; line_d = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (dut_vec() !== model_vec() || locked !== 1'b0)
                begin errors++; $display("FAIL reset_unsync: got %h required %h", dut_vec(), model_vec()); end
        end
        $display("reset: outputs idle, no sampling while unlocked");
    endtask

    task automatic test_basic();
        logic [W-1:0] got [4];
        int           cnt [4];
        tx_word[0] = 8'hA5; tx_word[1] = 8'h3C; tx_word[2] = 8'hFF; tx_word[3] = 8'h01;
        for (int c = 0; c < 4; c++) begin vld_en[c] = 1; cnt[c] = 0; got[c] = '0; end
        bus.ch_ready = 4'hF;
        // Wait for slot 0 so the lock pulse is a clean boundary.
        line_vld = 0; frame_start = 1'b1; step(); frame_start = 1'b0;
        checks++;
        if (dut_vec() !== model_vec() || locked !== 1'b1 || sel !== 2'd0)
            begin errors++; $display("FAIL basic_lock: got %h required %h", dut_vec(), model_vec()); end
        for (int k = 0; k < 32; k++) begin
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL basic_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
            for (int c = 0; c < 4; c++)
                if (bus.ch_valid[c]) begin cnt[c]++; got[c] = bus.ch_data[c*W +: W]; end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (cnt[c] !== 1 || got[c] !== tx_word[c])
                begin errors++; $display("FAIL basic_word ch%0d: got %h x%0d required %h x1", c, got[c], cnt[c], tx_word[c]); end
            $display("basic: ch%0d received %h", c, got[c]);
        end
    endtask

    task automatic test_ovf();
        tx_word[0] = 8'h00; tx_word[1] = 8'h00; tx_word[2] = 8'h11; tx_word[3] = 8'h00;
        bus.ch_ready = 4'b1011;
        for (int k = 0; k < 64; k++) begin
            if (k == 32) tx_word[2] = 8'h22;
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL ovf_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
        end
        checks++;
        if (bus.ch_data[2*W +: W] !== 8'h11 || bus.ch_valid[2] !== 1'b1 || bus.ovf[2] !== 1'b1)
            begin errors++; $display("FAIL ovf_hold: got data=%h v=%b ovf=%b required data=11 v=1 ovf=1",
                   bus.ch_data[2*W +: W], bus.ch_valid[2], bus.ovf[2]); end
        bus.ovf_clr = 4'b0100;
        drive(0);
        bus.ovf_clr = 4'b0000;
        checks++;
        if (bus.ovf[2] !== 1'b0 || bus.ch_valid[2] !== 1'b1 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL ovf_clear: got ovf=%b v=%b required ovf=0 v=1", bus.ovf[2], bus.ch_valid[2]); end
        bus.ch_ready = 4'hF;
        drive(0);
        checks++;
        if (bus.ch_valid[2] !== 1'b0 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL ovf_drain: got v=%b required v=0", bus.ch_valid[2]); end
        $display("ovf: ch2 held 11, second word dropped, flag cleared");
        // Realign to slot 0 for the next scenario.
        while (m_sel != 0) drive(0);
    endtask

    task automatic test_skip();
        logic [W-1:0] got1;
        logic [W-1:0] got0;
        got1 = '0; got0 = '0;
        tx_word[0] = 8'h0F; tx_word[1] = 8'h5A; tx_word[2] = 8'h33; tx_word[3] = 8'h96;
        for (int c = 0; c < 4; c++) vld_en[c] = 1;
        bus.ch_ready = 4'hF;
        for (int k = 0; k < 44; k++) begin
            vld_en[1] = !(k >= 8 && k < 20);
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL skip_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
            if (bus.ch_valid[1] && got1 == '0) got1 = bus.ch_data[1*W +: W];
            if (bus.ch_valid[0] && got0 == '0) got0 = bus.ch_data[0*W +: W];
        end
        vld_en[1] = 1;
        checks++;
        if (got1 !== 8'h5A || got0 !== 8'h0F)
            begin errors++; $display("FAIL skip_words: got ch1=%h ch0=%h required ch1=5A ch0=0F", got1, got0); end
        $display("skip: ch1 received %h across idle slots, ch0 received %h", got1, got0);
    endtask

    task automatic test_resync();
        logic [W-1:0] got;
        int           cnt;
        int           guard;
        got = '0; cnt = 0;
        for (int c = 0; c < 4; c++) tx_word[c] = 8'hC3;
        guard = 0;
        while (m_sel != 1 && guard < 8) begin drive(0); guard++; end
        checks++;
        if (m_sel != 1)
            begin errors++; $display("FAIL resync_align: got slot %0d required 1", m_sel); end
        drive(1);
        checks++;
        if (sync_err !== 1'b1 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL resync_pulse: got %h required %h", dut_vec(), model_vec()); end
        for (int k = 0; k < 32; k++) begin
            drive(0);
            checks++;
            if (dut_vec() !== model_vec() || (k == 0 && sync_err !== 1'b0))
                begin errors++; $display("FAIL resync_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
            if (bus.ch_valid[0]) begin cnt++; got = bus.ch_data[0 +: W]; end
        end
        checks++;
        if (got !== 8'hC3 || cnt !== 1)
            begin errors++; $display("FAIL resync_word: got %h x%0d required C3 x1", got, cnt); end
        guard = 0;
        while (m_sel != 3 && guard < 8) begin drive(0); guard++; end
        drive(1);
        checks++;
        if (sync_err !== 1'b0 || locked !== 1'b1 || sel !== 2'd0 || dut_vec() !== model_vec())
            begin errors++; $display("FAIL resync_boundary: got %h required %h", dut_vec(), model_vec()); end
        $display("resync: pulse seen, ch0 received %h, boundary frame_start silent", got);
    endtask

    task automatic test_back_to_back();
        bit seen;
        bit hit;
        bit last;
        bus.ch_ready = 4'b1110;
        tx_word[0] = 8'h81;
        seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL b2b_fill %0d: got %h required %h", k, dut_vec(), model_vec()); end
            seen = bus.ch_valid[0];
        end
        checks++;
        if (!seen)
            begin errors++; $display("FAIL b2b_timeout: got no ch0 valid required valid within 64 cycles"); end
        tx_word[0] = 8'h7E;
        hit = 0;
        for (int k = 0; k < 64 && !hit; k++) begin
            last = (m_sel == 0) && (m_n[0] == W - 1);
            if (last) bus.ch_ready[0] = 1'b1;
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL b2b_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
            if (last) begin
                hit = 1;
                checks++;
                if (bus.ch_valid[0] !== 1'b1 || bus.ch_data[0 +: W] !== 8'h7E || bus.ovf[0] !== 1'b0)
                    begin errors++; $display("FAIL b2b_reload: got v=%b data=%h ovf=%b required v=1 data=7E ovf=0",
                           bus.ch_valid[0], bus.ch_data[0 +: W], bus.ovf[0]); end
            end
        end
        checks++;
        if (!hit)
            begin errors++; $display("FAIL b2b_timeout2: got no last bit required one within 64 cycles"); end
        $display("b2b: ch0 reloaded with %h on accept cycle", bus.ch_data[0 +: W]);
        bus.ch_ready = 4'hF;
    endtask

    task automatic test_random();
        int words;
        words = 0;
        for (int k = 0; k < 500; k++) begin
            line_d       = 1'($urandom_range(0, 1));
            line_vld     = ($urandom_range(0, 3) != 0);
            bus.ch_ready = 4'($urandom);
            bus.ovf_clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            frame_start  = ($urandom_range(0, 39) == 0);
            step();
            frame_start  = 1'b0;
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL random_cycle %0d: got %h required %h", k, dut_vec(), model_vec()); end
            for (int c = 0; c < 4; c++)
                if (bus.ch_valid[c] && bus.ch_ready[c]) words++;
        end
        bus.ch_ready = 4'hF; bus.ovf_clr = '0;
        $display("random: 500 cycles, %0d word transfers observed", words);
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin tx_word[c] = 8'h6B; vld_en[c] = 1; end
        repeat (6) drive(0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (dut_vec() !== '0)
            begin errors++; $display("FAIL async_reset: got %h required 0", dut_vec()); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drive(0);
            checks++;
            if (dut_vec() !== model_vec() || bus.ch_valid !== 4'b0 || locked !== 1'b0)
                begin errors++; $display("FAIL async_unsync %0d: got %h required %h", k, dut_vec(), model_vec()); end
        end
        while (m_sel != 3) drive(0);
        drive(1);
        for (int k = 0; k < 32; k++) begin
            drive(0);
            checks++;
            if (dut_vec() !== model_vec())
                begin errors++; $display("FAIL async_relock %0d: got %h required %h", k, dut_vec(), model_vec()); end
        end
        checks++;
        if (bus.ch_data[3*W +: W] !== 8'h6B)
            begin errors++; $display("FAIL async_word: got %h required 6B", bus.ch_data[3*W +: W]); end
        $display("async reset: cleared between edges, relocked, ch3 data %h", bus.ch_data[3*W +: W]);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ovf();
        test_skip();
        test_resync();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion required finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule : tb_tdm_demux_4ch
